// File: rtl/mux.sv
// Two-input mux with a registered copy of its output and saturating
// counters for select changes and value-changing captures.
module mux #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  output logic [WIDTH-1:0] y,
  input  logic             s,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i0,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] y_q,
  output logic             q_valid,
  output logic [CNT_W-1:0] sel_cnt,
  output logic [CNT_W-1:0] out_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] r_yq;
  logic             r_qValid;
  logic             r_sPrev;
  logic             r_sPrevValid;
  logic [CNT_W-1:0] r_selCnt;
  logic [CNT_W-1:0] r_outCnt;
  logic             w_selChanged;
  logic             w_outChanged;

  // A ternary merges i0/i1 bitwise when s is unknown: agreeing bits pass, others go X.
  assign y = s ? i1 : i0;

  assign w_selChanged = r_sPrevValid && (s != r_sPrev);
  assign w_outChanged = en && (y != r_yq);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_yq         <= '0;
      r_qValid     <= 1'b0;
      r_sPrev      <= 1'b0;
      r_sPrevValid <= 1'b0;
      r_selCnt     <= '0;
      r_outCnt     <= '0;
    end else begin
      r_sPrev      <= s;
      r_sPrevValid <= 1'b1;
      if (en) begin
        r_yq     <= y;
        r_qValid <= 1'b1;
      end
      if (w_selChanged && (r_selCnt != CNT_MAX)) begin
        r_selCnt <= r_selCnt + CNT_W'(1);
      end
      if (w_outChanged && (r_outCnt != CNT_MAX)) begin
        r_outCnt <= r_outCnt + CNT_W'(1);
      end
    end
  end

  assign y_q     = r_yq;
  assign q_valid = r_qValid;
  assign sel_cnt = r_selCnt;
  assign out_cnt = r_outCnt;

endmodule

// File: tb/tb_mux.sv
// Scoreboard bench for mux: a default instance plus a CNT_W=2 instance
// sharing the same stimulus to exercise counter saturation.
module tb_mux;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       s;
  logic       i1;
  logic       i0;
  logic       y;
  logic       yQ;
  logic       qValid;
  logic [7:0] selCnt;
  logic [7:0] outCnt;
  logic       satY;
  logic       satYQ;
  logic       satQValid;
  logic [1:0] satSelCnt;
  logic [1:0] satOutCnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         kind;
    logic [7:0] exp;
    string      tag;
  } chk_t;

  chk_t sb[$];

  // Reference model state
  logic mYq;
  logic mQv;
  logic mSPrev;
  logic mPrevValid;
  int   mSel;
  int   mOut;
  int   mSatSel;

  mux dut (
    .y(y), .s(s), .i1(i1), .i0(i0), .clk(clk), .rst_n(rst_n), .en(en),
    .y_q(yQ), .q_valid(qValid), .sel_cnt(selCnt), .out_cnt(outCnt)
  );

  mux #(.WIDTH(1), .CNT_W(2)) dutSat (
    .y(satY), .s(s), .i1(i1), .i0(i0), .clk(clk), .rst_n(rst_n), .en(en),
    .y_q(satYQ), .q_valid(satQValid), .sel_cnt(satSelCnt), .out_cnt(satOutCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] observe(input int kind);
    case (kind)
      0:       return {7'b0, y};
      1:       return {7'b0, yQ};
      2:       return {7'b0, qValid};
      3:       return selCnt;
      4:       return outCnt;
      5:       return {6'b0, satSelCnt};
      default: return 8'hEE;
    endcase
  endfunction

  task automatic expectVal(input int kind, input logic [7:0] val, input string tag);
    chk_t c;
    c.kind = kind;
    c.exp  = val;
    c.tag  = tag;
    sb.push_back(c);
  endtask

  task automatic checkOutput();
    chk_t       c;
    logic [7:0] obs;
    while (sb.size() > 0) begin
      c   = sb.pop_front();
      obs = observe(c.kind);
      checks++;
      assert (obs === c.exp) else begin
        errors++;
        $error("[TB] FAIL %s observed %0d expected %0d", c.tag, obs, c.exp);
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic sv,
                               input logic v1, input logic v0);
    rst_n = r;
    en    = e;
    s     = sv;
    i1    = v1;
    i0    = v0;
  endtask

  // Advance the model by one edge, queue its predictions, then clock the DUTs.
  task automatic clockStep(input string tag);
    logic yExp;
    yExp = s ? i1 : i0;
    if (!rst_n) begin
      mYq = 1'b0; mQv = 1'b0; mSel = 0; mOut = 0; mSatSel = 0;
      mPrevValid = 1'b0;
    end else begin
      if (en) begin
        if (yExp != mYq && mOut < 255) mOut++;
        mYq = yExp;
        mQv = 1'b1;
      end
      if (mPrevValid && s != mSPrev) begin
        if (mSel < 255) mSel++;
        if (mSatSel < 3) mSatSel++;
      end
      mSPrev     = s;
      mPrevValid = 1'b1;
    end
    expectVal(0, {7'b0, yExp}, {tag, ":y"});
    expectVal(1, {7'b0, mYq},  {tag, ":y_q"});
    expectVal(2, {7'b0, mQv},  {tag, ":q_valid"});
    expectVal(3, 8'(mSel),     {tag, ":sel_cnt"});
    expectVal(4, 8'(mOut),     {tag, ":out_cnt"});
    expectVal(5, 8'(mSatSel),  {tag, ":sat_sel_cnt"});
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [7:0] sweepY;
    logic [2:0] sweepIn;
    sweepY = 8'b1100_1010;
    mYq = 1'b0; mQv = 1'b0; mSPrev = 1'b0; mPrevValid = 1'b0;
    mSel = 0; mOut = 0; mSatSel = 0;

    // Combinational sweep over (s,i1,i0) with the block held in reset
    for (int k = 0; k < 8; k++) begin
      sweepIn = 3'(k);
      applyStimulus(1'b0, 1'b0, sweepIn[2], sweepIn[1], sweepIn[0]);
      expectVal(0, {7'b0, sweepY[k]}, $sformatf("sweep%0d:y", k));
      #1;
      checkOutput();
    end

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    clockStep("rst0");
    clockStep("rst1");
    expectVal(0, 8'd1, "rst:y");
    expectVal(1, 8'd0, "rst:y_q");
    expectVal(2, 8'd0, "rst:q_valid");
    expectVal(3, 8'd0, "rst:sel_cnt");
    expectVal(4, 8'd0, "rst:out_cnt");
    checkOutput();

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    clockStep("cap");
    expectVal(1, 8'd1, "cap:y_q");
    expectVal(2, 8'd1, "cap:q_valid");
    expectVal(4, 8'd1, "cap:out_cnt");
    expectVal(3, 8'd0, "cap:first_edge_sel");
    checkOutput();

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    clockStep("hold");
    expectVal(0, 8'd0, "hold:y");
    expectVal(1, 8'd1, "hold:y_q");
    expectVal(4, 8'd1, "hold:out_cnt");
    checkOutput();

    // Five select toggles with en alternating
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, k[0], ~s, 1'b1, 1'b0);
      clockStep($sformatf("tog%0d", k));
    end
    expectVal(3, 8'd5, "tog:sel_cnt");
    checkOutput();

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    clockStep("satRst");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    clockStep("satFirst");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'b1, ~s, 1'b0, 1'b1);
      clockStep($sformatf("sat%0d", k));
    end
    expectVal(5, 8'd3, "sat:sel_cnt");
    expectVal(3, 8'd6, "sat:wide_sel_cnt");
    checkOutput();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 1'b0, ~s, 1'b0, 1'b1);
      clockStep($sformatf("satHold%0d", k));
    end
    expectVal(5, 8'd3, "satHold:sel_cnt");
    checkOutput();

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    clockStep("midRst");
    expectVal(0, 8'd0, "midRst:y");
    expectVal(1, 8'd0, "midRst:y_q");
    expectVal(2, 8'd0, "midRst:q_valid");
    expectVal(3, 8'd0, "midRst:sel_cnt");
    expectVal(4, 8'd0, "midRst:out_cnt");
    expectVal(5, 8'd0, "midRst:sat_sel_cnt");
    checkOutput();
    s = 1'b0;
    #1;
    expectVal(0, 8'd1, "midRst:y_tracks");
    checkOutput();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux.md
MUX -- requirements
Module: mux

Interface
REQ-001 Parameter WIDTH, default 1, data width of i0, i1, y and y_q.
REQ-002 Parameter CNT_W, default 8, width of the event counters.
REQ-003 Port clk  input  1  single clock; all sequential logic updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port y  output  WIDTH  combinational mux output.
REQ-006 Port s  input  1  select: 0 selects i0, 1 selects i1.
REQ-007 Port i1  input  WIDTH  data input selected when s=1.
REQ-008 Port i0  input  WIDTH  data input selected when s=0.
REQ-009 Port en  input  1  capture enable for the registered path.
REQ-010 Port y_q  output  WIDTH  registered copy of y.
REQ-011 Port q_valid  output  1  y_q holds a value captured since the last reset.
REQ-012 Port sel_cnt  output  CNT_W  count of clock edges on which s differed from its previous sampled value.
REQ-013 Port out_cnt  output  CNT_W  count of y_q updates that changed y_q's value.
REQ-014 Port declaration order SHALL be y, s, i1, i0, clk, rst_n, en, y_q, q_valid, sel_cnt, out_cnt, so the first four ports are usable positionally as (y, s, i1, i0).

Function
REQ-015 y SHALL equal i0 when s=0 and i1 when s=1, purely combinational, zero latency, independent of clk, rst_n and en.
REQ-016 y SHALL settle within the same simulation time step as any input change; no clock is required for y.
REQ-017 When s is X or Z, y SHALL equal i0 where i0 and i1 agree bitwise and X elsewhere.
REQ-018 On a rising clk edge with rst_n=1 and en=1: y_q <= y, q_valid <= 1.
REQ-019 On a rising clk edge with rst_n=1 and en=0: y_q and q_valid SHALL hold.
REQ-020 The block SHALL keep an internal s_prev register, loaded with s on every non-reset edge regardless of en.
REQ-021 sel_cnt SHALL increment by 1 on a non-reset edge when s != s_prev, regardless of en.
REQ-022 out_cnt SHALL increment by 1 on a non-reset edge when en=1 and y != y_q.
REQ-023 Both counters SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-024 The first edge after reset SHALL NOT count a select change (s_prev is loaded, not compared).
REQ-025 The first capture after reset SHALL count toward out_cnt only if y differs from the reset value of y_q (all zeros).
REQ-026 Simultaneous s change and en=1 on one edge: sel_cnt and out_cnt update independently on that same edge.

Reset
REQ-027 On a rising clk edge with rst_n=0: y_q=0, q_valid=0, sel_cnt=0, out_cnt=0, s_prev first-edge flag cleared; this overrides en.
REQ-028 Reset SHALL NOT affect y; y tracks s/i0/i1 during reset.
REQ-029 Reset asserted mid-operation SHALL clear all registers on the next edge, with no partial counts retained.

Verification
REQ-030 Exhaustive combinational sweep, no clock: all 8 (s,i1,i0) combinations 000..111, 1 time unit each -> y = 0,1,0,1,0,0,1,1.
REQ-031 Reset: rst_n=0 for 2 edges with en=1, s=1, i1=1 -> y=1 and y_q=0, q_valid=0, both counters 0.
REQ-032 Capture: rst_n=1, en=1, s=1, i1=1, i0=0, one edge -> y_q=1, q_valid=1, out_cnt=1; then en=0, i1=0, one edge -> y=0, y_q=1, out_cnt=1.
REQ-033 Select counting: toggle s on each of 5 consecutive edges after the first post-reset edge -> sel_cnt=5, independent of en.
REQ-034 Saturation: CNT_W=2, toggle s on 6 counted edges -> sel_cnt=3 and stays at 3.
REQ-035 Mid-run reset: counters non-zero, rst_n=0 for one edge -> all registered outputs 0 on that edge, y unaffected.
